// File: rtl/reservation_station_if.sv
// Dispatch / CDB / functional-unit bundle for one reservation station entry.
// slave = the station, master = dispatch, CDB and FU side.
interface reservation_station_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4
);
  logic              DISPATCH_VALID;
  logic [FUNC_W-1:0] DISPATCH_FUNC;
  logic [DATA_W-1:0] DISPATCH_VJ;
  logic [TAG_W-1:0]  DISPATCH_QJ;
  logic [DATA_W-1:0] DISPATCH_VK;
  logic [TAG_W-1:0]  DISPATCH_QK;
  logic              CDB_VALID;
  logic [TAG_W-1:0]  CDB_TAG;
  logic [DATA_W-1:0] CDB_DATA;
  logic              FU_READY;
  logic              ISSUE_VALID;
  logic [FUNC_W-1:0] ISSUE_FUNC;
  logic [DATA_W-1:0] ISSUE_A;
  logic [DATA_W-1:0] ISSUE_B;
  logic [TAG_W-1:0]  ISSUE_TAG;
  logic              BUSY;
  logic              PROTO_ERR;

  modport master (
    output DISPATCH_VALID, DISPATCH_FUNC,
    output DISPATCH_VJ, DISPATCH_QJ,
    output DISPATCH_VK, DISPATCH_QK,
    output CDB_VALID, CDB_TAG, CDB_DATA,
    output FU_READY,
    input  ISSUE_VALID, ISSUE_FUNC,
    input  ISSUE_A, ISSUE_B, ISSUE_TAG,
    input  BUSY, PROTO_ERR
  );

  modport slave (
    input  DISPATCH_VALID, DISPATCH_FUNC,
    input  DISPATCH_VJ, DISPATCH_QJ,
    input  DISPATCH_VK, DISPATCH_QK,
    input  CDB_VALID, CDB_TAG, CDB_DATA,
    input  FU_READY,
    output ISSUE_VALID, ISSUE_FUNC,
    output ISSUE_A, ISSUE_B, ISSUE_TAG,
    output BUSY, PROTO_ERR
  );
endinterface

// File: rtl/reservation_station.sv
// Single Tomasulo reservation station entry: capture, CDB snoop, issue, release.
// Optional sticky protocol checker enabled by defining RS_PROTO_CHECK_EN.
module reservation_station #(
  parameter int RS_TAG      = 4,
  parameter int TAG_W       = 3,
  parameter int INVALID_TAG = 7,
  parameter int DATA_W      = 32,
  parameter int FUNC_W      = 4
) (
  input logic CLK,
  input logic RST,
  reservation_station_if.slave io
);

  localparam logic [TAG_W-1:0] INV  = TAG_W'(INVALID_TAG);
  localparam logic [TAG_W-1:0] SELF = TAG_W'(RS_TAG);

  typedef enum logic [1:0] {
    FREE,
    WAIT_OPS,
    READY,
    EXEC
  } state_e;

  state_e            state_q, state_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  qj_q, qj_d;
  logic [TAG_W-1:0]  qk_q, qk_d;

  logic fwd_j, fwd_k;
  logic hit_j, hit_k;
  logic self_bc;

  // An invalid tag on the CDB never wakes an operand.
  always_comb begin
    fwd_j = io.CDB_VALID && (io.CDB_TAG != INV)
         && (io.CDB_TAG == io.DISPATCH_QJ);
    fwd_k = io.CDB_VALID && (io.CDB_TAG != INV)
         && (io.CDB_TAG == io.DISPATCH_QK);
    hit_j = io.CDB_VALID && (io.CDB_TAG != INV)
         && (io.CDB_TAG == qj_q);
    hit_k = io.CDB_VALID && (io.CDB_TAG != INV)
         && (io.CDB_TAG == qk_q);
    self_bc = io.CDB_VALID && (io.CDB_TAG == SELF);
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    unique case (state_q)
      FREE: begin
        if (io.DISPATCH_VALID) begin
          func_d = io.DISPATCH_FUNC;
          a_d    = fwd_j ? io.CDB_DATA : io.DISPATCH_VJ;
          qj_d   = fwd_j ? INV : io.DISPATCH_QJ;
          b_d    = fwd_k ? io.CDB_DATA : io.DISPATCH_VK;
          qk_d   = fwd_k ? INV : io.DISPATCH_QK;
          if ((qj_d == INV) && (qk_d == INV)) begin
            state_d = READY;
          end else begin
            state_d = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        if (hit_j) begin
          a_d  = io.CDB_DATA;
          qj_d = INV;
        end
        if (hit_k) begin
          b_d  = io.CDB_DATA;
          qk_d = INV;
        end
        if ((qj_d == INV) && (qk_d == INV)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (io.FU_READY) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (self_bc) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      qj_q    <= INV;
      qk_q    <= INV;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
    end
  end

  assign io.BUSY        = (state_q != FREE);
  assign io.ISSUE_VALID = (state_q == READY);
  assign io.ISSUE_FUNC  = func_q;
  assign io.ISSUE_A     = a_q;
  assign io.ISSUE_B     = b_q;
  assign io.ISSUE_TAG   = SELF;

`ifdef RS_PROTO_CHECK_EN
  logic perr_q, perr_d;
  logic busy_disp, stray_bc, self_dep;

  always_comb begin
    busy_disp = io.DISPATCH_VALID && (state_q != FREE);
    stray_bc  = self_bc && (state_q != EXEC);
    self_dep  = io.DISPATCH_VALID
             && ((io.DISPATCH_QJ == SELF) || (io.DISPATCH_QK == SELF));
    perr_d    = perr_q || busy_disp || stray_bc || self_dep;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign io.PROTO_ERR = perr_q;
`else
  assign io.PROTO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed cycle table, then random traffic
// against a transaction-level model of the entry.
module tb_reservation_station;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  reservation_station_if bus ();

  reservation_station #(
    .RS_TAG(4), .TAG_W(3), .INVALID_TAG(7), .DATA_W(32), .FUNC_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .io (bus)
  );

  typedef struct {
    bit        rst;
    bit        dv;
    bit [3:0]  func;
    bit [31:0] vj;
    bit [2:0]  qj;
    bit [31:0] vk;
    bit [2:0]  qk;
    bit        cv;
    bit [2:0]  ctag;
    bit [31:0] cdata;
    bit        fu;
    bit        e_busy;
    bit        e_iv;
    bit        chk_ops;
    bit [3:0]  e_func;
    bit [31:0] e_a;
    bit [31:0] e_b;
    bit        e_perr;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t row(
    int rst, int dv, int func, int vj, int qj, int vk, int qk,
    int cv, int ctag, int cdata, int fu,
    int eb, int eiv, int chk, int ef, int ea, int ebv, int ep);
    vec_t r;
    r.rst = 1'(rst); r.dv = 1'(dv); r.func = 4'(func);
    r.vj = 32'(vj); r.qj = 3'(qj); r.vk = 32'(vk); r.qk = 3'(qk);
    r.cv = 1'(cv); r.ctag = 3'(ctag); r.cdata = 32'(cdata);
    r.fu = 1'(fu); r.e_busy = 1'(eb); r.e_iv = 1'(eiv);
    r.chk_ops = 1'(chk); r.e_func = 4'(ef);
    r.e_a = 32'(ea); r.e_b = 32'(ebv); r.e_perr = 1'(ep);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit dv, bit [3:0] func,
                       bit [31:0] vj, bit [2:0] qj,
                       bit [31:0] vk, bit [2:0] qk,
                       bit cv, bit [2:0] ctag, bit [31:0] cdata, bit fu);
    RST = rst;
    bus.DISPATCH_VALID = dv;
    bus.DISPATCH_FUNC  = func;
    bus.DISPATCH_VJ    = vj;
    bus.DISPATCH_QJ    = qj;
    bus.DISPATCH_VK    = vk;
    bus.DISPATCH_QK    = qk;
    bus.CDB_VALID      = cv;
    bus.CDB_TAG        = ctag;
    bus.CDB_DATA       = cdata;
    bus.FU_READY       = fu;
  endtask

  // Reference model: an entry either holds a task or not; a held task
  // has been sent to the FU or not; each operand has a pending tag or -1.
  bit        m_held, m_sent, m_perr;
  int        m_ta, m_tb;
  bit [31:0] m_a, m_b;
  bit [3:0]  m_func;

  function automatic int pend(bit [2:0] q);
    return (q == 3'd7) ? -1 : int'(q);
  endfunction

  task automatic model_step();
    bit cv; int ct; bit can_go;
    cv = bus.CDB_VALID;
    ct = int'(bus.CDB_TAG);
    if (RST) begin
      m_held = 0; m_sent = 0; m_perr = 0;
      m_ta = -1; m_tb = -1; m_a = 0; m_b = 0; m_func = 0;
      return;
    end
    if (bus.DISPATCH_VALID && m_held) m_perr = 1;
    if (cv && ct == 4 && !(m_held && m_sent)) m_perr = 1;
    if (bus.DISPATCH_VALID &&
        (bus.DISPATCH_QJ == 3'd4 || bus.DISPATCH_QK == 3'd4)) m_perr = 1;
    if (!m_held) begin
      if (bus.DISPATCH_VALID) begin
        m_held = 1; m_sent = 0;
        m_func = bus.DISPATCH_FUNC;
        m_ta = pend(bus.DISPATCH_QJ);
        m_tb = pend(bus.DISPATCH_QK);
        m_a = bus.DISPATCH_VJ;
        m_b = bus.DISPATCH_VK;
        if (cv && m_ta >= 0 && m_ta == ct) begin m_a = bus.CDB_DATA; m_ta = -1; end
        if (cv && m_tb >= 0 && m_tb == ct) begin m_b = bus.CDB_DATA; m_tb = -1; end
      end
    end else begin
      can_go = !m_sent && m_ta < 0 && m_tb < 0;
      if (cv && m_ta >= 0 && m_ta == ct) begin m_a = bus.CDB_DATA; m_ta = -1; end
      if (cv && m_tb >= 0 && m_tb == ct) begin m_b = bus.CDB_DATA; m_tb = -1; end
      if (can_go && bus.FU_READY) m_sent = 1;
      else if (m_sent && cv && ct == 4) m_held = 0;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 7, 0, 7, 0, 0, 0, 0);

    // rst dv f vj qj vk qk cv ct cd fu | busy iv chk f a b perr
    tbl.push_back(row(1,0,0,0,7,0,7, 0,0,0,0,        0,0,1,0,0,0,0));
    tbl.push_back(row(0,1,2,5,7,9,7, 0,0,0,1,        1,1,1,2,5,9,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,4,0,1,        0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,3,'hdead,0,3,7, 0,0,0,0,   1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,0,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,0,'h1234,0,   1,1,1,3,'h1234,3,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,0,        1,1,1,3,'h1234,3,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,0,        1,1,1,3,'h1234,3,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,0,        1,1,1,3,'h1234,3,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,4,0,0,        0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,5,0,2,0,2, 1,2,'habcd,0,   1,1,1,5,'habcd,'habcd,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,4,0,0,        0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,1,0,1,'h77,7, 0,0,0,0,     1,0,0,0,0,0,0));
    tbl.push_back(row(0,1,9,'h55,7,'h66,7, 0,0,0,0,  1,0,0,0,0,0,1));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,1,'h11,0,     1,1,1,1,'h11,'h77,1));
    tbl.push_back(row(1,0,0,0,7,0,7, 0,0,0,0,        0,0,1,0,0,0,0));
    tbl.push_back(row(0,1,6,'h21,7,'h22,7, 0,0,0,0,  1,1,1,6,'h21,'h22,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,4,0,0,        0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,7,'h31,7,'h32,7, 1,7,'hbad,0, 1,1,1,7,'h31,'h32,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 1,4,0,0,        0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,8,1,7,2,7, 0,0,0,0,        1,1,1,8,1,2,0));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(row(0,1,9,3,7,4,7, 1,4,0,0,        0,0,0,0,0,0,1));
    tbl.push_back(row(0,0,0,0,7,0,7, 0,0,0,0,        0,0,0,0,0,0,1));
    tbl.push_back(row(1,0,0,0,7,0,7, 0,0,0,0,        0,0,1,0,0,0,0));

    foreach (tbl[i]) begin
      vec_t r;
      bit ep;
      r = tbl[i];
      drive(r.rst, r.dv, r.func, r.vj, r.qj, r.vk, r.qk,
            r.cv, r.ctag, r.cdata, r.fu);
      model_step();
      @(posedge CLK);
      #1;
`ifdef RS_PROTO_CHECK_EN
      ep = r.e_perr;
`else
      ep = 1'b0;
`endif
      chk($sformatf("row%0d busy", i), 32'(bus.BUSY), 32'(r.e_busy));
      chk($sformatf("row%0d issue_valid", i), 32'(bus.ISSUE_VALID), 32'(r.e_iv));
      chk($sformatf("row%0d proto_err", i), 32'(bus.PROTO_ERR), 32'(ep));
      if (r.chk_ops) begin
        chk($sformatf("row%0d func", i), 32'(bus.ISSUE_FUNC), 32'(r.e_func));
        chk($sformatf("row%0d a", i), bus.ISSUE_A, r.e_a);
        chk($sformatf("row%0d b", i), bus.ISSUE_B, r.e_b);
      end
      if (r.e_iv)
        chk($sformatf("row%0d tag", i), 32'(bus.ISSUE_TAG), 32'd4);
    end

    for (int c = 0; c < 600; c++) begin
      bit rst, dv, cv, fu, ep;
      bit [2:0] qj, qk, ct;
      rst = ($urandom_range(0, 59) == 0);
      dv  = ($urandom_range(0, 2) == 0);
      qj  = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      qk  = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      cv  = ($urandom_range(0, 1) == 0);
      ct  = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      fu  = ($urandom_range(0, 1) == 0);
      drive(rst, dv, 4'($urandom), $urandom, qj, $urandom, qk,
            cv, ct, $urandom, fu);
      model_step();
      @(posedge CLK);
      #1;
`ifdef RS_PROTO_CHECK_EN
      ep = m_perr;
`else
      ep = 1'b0;
`endif
      chk($sformatf("rnd%0d busy", c), 32'(bus.BUSY), 32'(m_held));
      chk($sformatf("rnd%0d issue_valid", c), 32'(bus.ISSUE_VALID),
          32'(m_held && !m_sent && m_ta < 0 && m_tb < 0));
      chk($sformatf("rnd%0d proto_err", c), 32'(bus.PROTO_ERR), 32'(ep));
      if (m_held && !m_sent && m_ta < 0 && m_tb < 0) begin
        chk($sformatf("rnd%0d func", c), 32'(bus.ISSUE_FUNC), 32'(m_func));
        chk($sformatf("rnd%0d a", c), bus.ISSUE_A, m_a);
        chk($sformatf("rnd%0d b", c), bus.ISSUE_B, m_b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
